// File: rtl/ctrl_pkg.sv
// Shared definitions for the layer sequencer: state encoding, address width and
// the beat shift amounts used to turn element counts into DMA addresses/lengths.
package ctrl_pkg;

  localparam int ADDRLEN         = 32;
  localparam int ADDR_BEAT_SHIFT = 6;
  localparam int LEN_DATA_SHIFT  = 2;
  localparam int LEN_INDX_SHIFT  = 6;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0000,
    ST_LDIN   = 4'b0001,
    ST_LDKRNL = 4'b0010,
    ST_LDINDX = 4'b0011,
    ST_CONV   = 4'b0100,
    ST_IFFT   = 4'b0101,
    ST_WIFFT  = 4'b0110,
    ST_DONE   = 4'b0111
  } ctrl_state_e;

  // One beat covers 64 bytes of DRAM.
  function automatic logic [ADDRLEN-1:0] beat_addr(input logic [ADDRLEN-1:0] base,
                                                   input logic [ADDRLEN-1:0] beats);
    return base + (beats << ADDR_BEAT_SHIFT);
  endfunction

endpackage

// File: rtl/ctrl_addr_gen.sv
// Combinational DMA address/length selection for the operand currently being loaded.
module ctrl_addr_gen
  import ctrl_pkg::*;
(
  input  ctrl_state_e        state_i,
  input  logic [11:0]        pdone_i,
  input  logic [9:0]         ndone_i,
  input  logic [9:0]         n_i,
  input  logic [9:0]         m_i,
  input  logic [9:0]         ns_i,
  input  logic [9:0]         ps_i,
  input  logic [ADDRLEN-1:0] addrin_i,
  input  logic [ADDRLEN-1:0] addrkrnl_i,
  input  logic [ADDRLEN-1:0] addrindx_i,
  output logic [ADDRLEN-1:0] rdaddr_o,
  output logic [15:0]        transferlen_o
);

  logic [ADDRLEN-1:0] in_beats_s;
  logic [ADDRLEN-1:0] krnl_beats_s;
  logic [19:0]        in_elems_s;
  logic [19:0]        krnl_elems_s;

  assign in_beats_s   = ADDRLEN'(pdone_i) * ADDRLEN'(n_i) + ADDRLEN'(ndone_i) * ADDRLEN'(ps_i);
  assign krnl_beats_s = ADDRLEN'(ndone_i) * ADDRLEN'(m_i);
  assign in_elems_s   = 20'(ns_i) * 20'(ps_i);
  assign krnl_elems_s = 20'(ns_i) * 20'(m_i);

  // Address/length mux; index data shares the kernel channel offset.
  always_comb begin
    rdaddr_o      = {ADDRLEN{1'b0}};
    transferlen_o = 16'd0;
    case (state_i)
      ST_LDIN: begin
        rdaddr_o      = beat_addr(addrin_i, in_beats_s);
        transferlen_o = 16'(in_elems_s >> LEN_DATA_SHIFT);
      end
      ST_LDKRNL: begin
        rdaddr_o      = beat_addr(addrkrnl_i, krnl_beats_s);
        transferlen_o = 16'(krnl_elems_s >> LEN_DATA_SHIFT);
      end
      ST_LDINDX: begin
        rdaddr_o      = beat_addr(addrindx_i, krnl_beats_s);
        transferlen_o = 16'(krnl_elems_s >> LEN_INDX_SHIFT);
      end
      default: begin
        rdaddr_o      = {ADDRLEN{1'b0}};
        transferlen_o = 16'd0;
      end
    endcase
  end

endmodule

// File: rtl/layer_control_top.sv
// Layer sequencer: walks tile/channel chunks issuing DMA loads, conv waits and IFFT triggers.
// Build option CTRL_KRNL_REUSE_EN skips kernel/index reloads when all channels fit one chunk.
module layer_control_top
  import ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic [9:0]         N,
  input  logic [9:0]         M,
  input  logic [11:0]        P,
  input  logic [9:0]         Ns,
  input  logic [9:0]         Ps,
  input  logic               inlast,
  input  logic               krnllast,
  input  logic               indxlast,
  input  logic [ADDRLEN-1:0] addrin,
  input  logic [ADDRLEN-1:0] addrkrnl,
  input  logic [ADDRLEN-1:0] addrindx,
  output logic               procin,
  output logic               prockrnl,
  output logic               procindx,
  output logic               innoneed,
  output logic               krnlnoneed,
  output logic               indxnoneed,
  output logic [ADDRLEN-1:0] rdaddr,
  output logic [15:0]        transferlen,
  output logic [9:0]         offsetaddrkrn,
  output logic               ifftstart,
  input  logic               ifftdone,
  input  logic               readynext,
  output logic               layrdone
);

  ctrl_state_e state_q, state_d;
  logic [11:0] pdone_q, pdone_d;
  logic [9:0]  ndone_q, ndone_d;
  logic [10:0] nsum_s;
  logic [12:0] psum_s;
  logic        skip_s;
  logic        skip_d_s;
  logic        procin_q, prockrnl_q, procindx_q;
  logic        krnlnoneed_q, indxnoneed_q;
  logic        ifftstart_q, layrdone_q;
  logic [9:0]  offset_q;

  // Sums are one bit wider so the end-of-loop compare never sees a wrapped counter.
  assign nsum_s = {1'b0, ndone_q} + {1'b0, Ns};
  assign psum_s = {1'b0, pdone_q} + {3'b000, Ps};

`ifdef CTRL_KRNL_REUSE_EN
  assign skip_s   = (N <= Ns) && (pdone_q != 12'd0);
  assign skip_d_s = (N <= Ns) && (pdone_d != 12'd0);
`else
  assign skip_s   = 1'b0;
  assign skip_d_s = 1'b0;
`endif

  // Next-state and counter update.
  always_comb begin
    state_d = state_q;
    pdone_d = pdone_q;
    ndone_d = ndone_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pdone_d = 12'd0;
          ndone_d = 10'd0;
          if ((N == 10'd0) || (P == 12'd0)) state_d = ST_DONE;
          else state_d = ST_LDIN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LDIN: begin
        if (inlast) state_d = ST_LDKRNL;
        else state_d = ST_LDIN;
      end
      ST_LDKRNL: begin
        if (skip_s || krnllast) state_d = ST_LDINDX;
        else state_d = ST_LDKRNL;
      end
      ST_LDINDX: begin
        if (skip_s || indxlast) state_d = ST_CONV;
        else state_d = ST_LDINDX;
      end
      ST_CONV: begin
        if (readynext) begin
          ndone_d = nsum_s[9:0];
          if (nsum_s < {1'b0, N}) state_d = ST_LDIN;
          else state_d = ST_IFFT;
        end else begin
          state_d = ST_CONV;
        end
      end
      ST_IFFT: state_d = ST_WIFFT;
      ST_WIFFT: begin
        if (ifftdone) begin
          pdone_d = psum_s[11:0];
          ndone_d = 10'd0;
          if (psum_s < {1'b0, P}) state_d = ST_LDIN;
          else state_d = ST_DONE;
        end else begin
          state_d = ST_WIFFT;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters and registered outputs; level outputs track the upcoming state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      pdone_q      <= 12'd0;
      ndone_q      <= 10'd0;
      procin_q     <= 1'b0;
      prockrnl_q   <= 1'b0;
      procindx_q   <= 1'b0;
      krnlnoneed_q <= 1'b0;
      indxnoneed_q <= 1'b0;
      offset_q     <= 10'd0;
      ifftstart_q  <= 1'b0;
      layrdone_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pdone_q      <= pdone_d;
      ndone_q      <= ndone_d;
      procin_q     <= (state_d == ST_LDIN);
      prockrnl_q   <= (state_d == ST_LDKRNL) && !skip_d_s;
      procindx_q   <= (state_d == ST_LDINDX) && !skip_d_s;
      krnlnoneed_q <= (state_d == ST_LDKRNL) && skip_d_s;
      indxnoneed_q <= (state_d == ST_LDINDX) && skip_d_s;
      offset_q     <= (state_d inside {ST_LDKRNL, ST_LDINDX, ST_CONV}) ? ndone_d : 10'd0;
      ifftstart_q  <= (state_q == ST_IFFT);
      layrdone_q   <= (state_q == ST_DONE);
    end
  end

  ctrl_addr_gen u_addr_gen (
    .state_i       (state_q),
    .pdone_i       (pdone_q),
    .ndone_i       (ndone_q),
    .n_i           (N),
    .m_i           (M),
    .ns_i          (Ns),
    .ps_i          (Ps),
    .addrin_i      (addrin),
    .addrkrnl_i    (addrkrnl),
    .addrindx_i    (addrindx),
    .rdaddr_o      (rdaddr),
    .transferlen_o (transferlen)
  );

  assign procin        = procin_q;
  assign prockrnl      = prockrnl_q;
  assign procindx      = procindx_q;
  assign innoneed      = 1'b0;
  assign krnlnoneed    = krnlnoneed_q;
  assign indxnoneed    = indxnoneed_q;
  assign offsetaddrkrn = offset_q;
  assign ifftstart     = ifftstart_q;
  assign layrdone      = layrdone_q;

endmodule

// File: tb/tb_layer_control_top.sv
// Scoreboard bench for layer_control_top: a loop-level layer model predicts the event
// stream; a monitor pops and compares each event the DUT presents.
module tb_layer_control_top;

`ifdef CTRL_KRNL_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  localparam int K_IN = 0, K_KRNL = 1, K_INDX = 2, K_KSKIP = 3, K_ISKIP = 4, K_IFFT = 5, K_DONE = 6;

  typedef struct packed {
    logic [2:0]  kind;
    logic [31:0] addr;
    logic [15:0] len;
    logic [9:0]  off;
  } ev_t;

  logic        clk, rstn, start;
  logic [9:0]  cfg_n, cfg_m, cfg_ns, cfg_ps;
  logic [11:0] cfg_p;
  logic        inlast, krnllast, indxlast, ifftdone, readynext;
  logic [31:0] addr_in, addr_krnl, addr_indx;
  logic        procin, prockrnl, procindx, innoneed, krnlnoneed, indxnoneed;
  logic [31:0] rdaddr;
  logic [15:0] transferlen;
  logic [9:0]  offsetaddrkrn;
  logic        ifftstart, layrdone;

  ev_t sb[$];
  int  n_checks = 0;
  int  n_fail = 0;
  int  done_seen = 0;
  int  ifft_seen = 0;
  bit  no_ready = 1'b0;

  layer_control_top dut (
    .clk(clk), .rstn(rstn), .start(start),
    .N(cfg_n), .M(cfg_m), .P(cfg_p), .Ns(cfg_ns), .Ps(cfg_ps),
    .inlast(inlast), .krnllast(krnllast), .indxlast(indxlast),
    .addrin(addr_in), .addrkrnl(addr_krnl), .addrindx(addr_indx),
    .procin(procin), .prockrnl(prockrnl), .procindx(procindx),
    .innoneed(innoneed), .krnlnoneed(krnlnoneed), .indxnoneed(indxnoneed),
    .rdaddr(rdaddr), .transferlen(transferlen), .offsetaddrkrn(offsetaddrkrn),
    .ifftstart(ifftstart), .ifftdone(ifftdone), .readynext(readynext),
    .layrdone(layrdone)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic ev_t mk(input int k, input logic [31:0] a, input logic [15:0] l, input logic [9:0] o);
    ev_t e;
    e.kind = 3'(k);
    e.addr = a;
    e.len  = l;
    e.off  = o;
    return e;
  endfunction

  // Layer walk expressed as plain nested loops over tile and channel chunks.
  task automatic model_push();
    int n_ch, m_ch, ns, ps, np;
    n_ch = int'(cfg_n); m_ch = int'(cfg_m); ns = int'(cfg_ns); ps = int'(cfg_ps); np = int'(cfg_p);
    if (n_ch != 0 && np != 0) begin
      for (int p = 0; p < np; p += ps) begin
        for (int n = 0; n < n_ch; n += ns) begin
          sb.push_back(mk(K_IN, addr_in + 32'((p * n_ch + n * ps) * 64), 16'((ns * ps) / 4), 10'd0));
          if (REUSE && n_ch <= ns && p != 0) begin
            sb.push_back(mk(K_KSKIP, 32'd0, 16'd0, 10'd0));
            sb.push_back(mk(K_ISKIP, 32'd0, 16'd0, 10'd0));
          end else begin
            sb.push_back(mk(K_KRNL, addr_krnl + 32'(n * m_ch * 64), 16'((ns * m_ch) / 4), 10'(n)));
            sb.push_back(mk(K_INDX, addr_indx + 32'(n * m_ch * 64), 16'((ns * m_ch) / 64), 10'(n)));
          end
        end
        sb.push_back(mk(K_IFFT, 32'd0, 16'd0, 10'd0));
      end
    end
    sb.push_back(mk(K_DONE, 32'd0, 16'd0, 10'd0));
  endtask

  task automatic take(input int k, output ev_t e);
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: actual kind %0d required none (scoreboard empty)", k);
      e = '0;
    end else begin
      e = sb.pop_front();
      if (int'(e.kind) != k) begin
        n_fail++;
        $display("FAIL event_kind: actual %0d required %0d", k, e.kind);
      end
    end
  endtask

  // Random handshakes every cycle; the DUT must ignore those its state does not expect.
  initial begin : responder
    inlast = 1'b0; krnllast = 1'b0; indxlast = 1'b0; ifftdone = 1'b0; readynext = 1'b0;
    forever begin
      @(negedge clk);
      inlast    = ($urandom_range(0, 2) == 0);
      krnllast  = ($urandom_range(0, 2) == 0);
      indxlast  = ($urandom_range(0, 2) == 0);
      ifftdone  = ($urandom_range(0, 2) == 0);
      readynext = no_ready ? 1'b0 : ($urandom_range(0, 2) == 0);
    end
  end

  initial begin : monitor
    logic pin_p, pk_p, px_p;
    ev_t  cur_in, cur_k, cur_x, tmp;
    pin_p = 1'b0; pk_p = 1'b0; px_p = 1'b0;
    cur_in = '0; cur_k = '0; cur_x = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rstn) begin
        pin_p = 1'b0; pk_p = 1'b0; px_p = 1'b0;
      end else begin
        if (pin_p) chk("procin_level", 32'(procin), 32'(!inlast));
        if (pk_p)  chk("prockrnl_level", 32'(prockrnl), 32'(!krnllast));
        if (px_p)  chk("procindx_level", 32'(procindx), 32'(!indxlast));
        if (procin && !pin_p)   take(K_IN, cur_in);
        if (prockrnl && !pk_p)  take(K_KRNL, cur_k);
        if (procindx && !px_p)  take(K_INDX, cur_x);
        if (procin) begin
          chk("in_addr", rdaddr, cur_in.addr);
          chk("in_len", 32'(transferlen), 32'(cur_in.len));
          chk("in_off", 32'(offsetaddrkrn), 32'(cur_in.off));
        end
        if (prockrnl) begin
          chk("krnl_addr", rdaddr, cur_k.addr);
          chk("krnl_len", 32'(transferlen), 32'(cur_k.len));
          chk("krnl_off", 32'(offsetaddrkrn), 32'(cur_k.off));
        end
        if (procindx) begin
          chk("indx_addr", rdaddr, cur_x.addr);
          chk("indx_len", 32'(transferlen), 32'(cur_x.len));
          chk("indx_off", 32'(offsetaddrkrn), 32'(cur_x.off));
        end
        if (krnlnoneed) take(K_KSKIP, tmp);
        if (indxnoneed) take(K_ISKIP, tmp);
        if (ifftstart) begin
          take(K_IFFT, tmp);
          ifft_seen++;
        end
        if (layrdone) begin
          take(K_DONE, tmp);
          done_seen++;
        end
        pin_p = procin; pk_p = prockrnl; px_p = procindx;
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_procin"}, 32'(procin), 32'd0);
    chk({tag, "_prockrnl"}, 32'(prockrnl), 32'd0);
    chk({tag, "_procindx"}, 32'(procindx), 32'd0);
    chk({tag, "_innoneed"}, 32'(innoneed), 32'd0);
    chk({tag, "_krnlnoneed"}, 32'(krnlnoneed), 32'd0);
    chk({tag, "_indxnoneed"}, 32'(indxnoneed), 32'd0);
    chk({tag, "_rdaddr"}, rdaddr, 32'd0);
    chk({tag, "_transferlen"}, 32'(transferlen), 32'd0);
    chk({tag, "_offset"}, 32'(offsetaddrkrn), 32'd0);
    chk({tag, "_ifftstart"}, 32'(ifftstart), 32'd0);
    chk({tag, "_layrdone"}, 32'(layrdone), 32'd0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_layer();
    int d0, cyc;
    d0 = done_seen;
    cyc = 0;
    model_push();
    pulse_start();
    while (done_seen == d0 && cyc < 6000) begin
      @(posedge clk);
      cyc++;
    end
    chk("layer_timeout", 32'(done_seen != d0), 32'd1);
    repeat (2) @(posedge clk);
    #2;
    chk("sb_empty", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic cfg_a();
    cfg_n = 10'd512; cfg_m = 10'd512; cfg_p = 12'd1152; cfg_ns = 10'd256; cfg_ps = 10'd288;
    addr_in = 32'h0; addr_krnl = 32'hF00; addr_indx = 32'hF0_0000;
  endtask

  initial begin : stim
    int i0, cyc, seen;
    logic prev;
    rstn = 1'b0; start = 1'b0;
    cfg_a();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rstn = 1'b1;

    // Reference layer: 2 channel chunks x 4 tile chunks.
    i0 = ifft_seen;
    run_layer();
    chk("ifft_count", 32'(ifft_seen - i0), 32'd4);

    // All channels fit one chunk: reuse candidate.
    cfg_n = 10'd256; cfg_ns = 10'd256; cfg_p = 12'd576; cfg_ps = 10'd288;
    run_layer();

    // Empty layer: layrdone two cycles after start, nothing else.
    cfg_p = 12'd0;
    model_push();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("p0_early", 32'(layrdone), 32'd0);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("p0_done", 32'(layrdone), 32'd1);
    repeat (2) @(posedge clk);
    #2;
    chk("p0_sb_empty", 32'(sb.size()), 32'd0);
    sb.delete();

    // Abort in the second channel chunk's conv wait, then restart.
    cfg_a();
    model_push();
    pulse_start();
    seen = 0; cyc = 0; prev = 1'b0;
    while (seen < 3 && cyc < 4000) begin
      @(posedge clk);
      #1;
      if (procindx && !prev) begin
        seen++;
        if (seen == 2) no_ready = 1'b1;
      end
      if (prev && !procindx && seen == 2) seen = 3;
      prev = procindx;
      cyc++;
    end
    chk("reach_conv", 32'(seen), 32'd3);
    repeat (3) @(posedge clk);
    #1;
    chk("conv_offset", 32'(offsetaddrkrn), 32'd256);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    sb.delete();
    no_ready = 1'b0;
    rstn = 1'b1;
    run_layer();

    // Random layers: small loop counts, or large values with few chunks.
    for (int t = 0; t < 8; t++) begin
      addr_in = $urandom(); addr_krnl = $urandom(); addr_indx = $urandom();
      cfg_m = 10'($urandom_range(1, 1023));
      if (t % 2 == 1) begin
        cfg_n  = 10'($urandom_range(512, 1023));
        cfg_ns = 10'(cfg_n / 10'd2 + 10'd1);
        cfg_p  = 12'($urandom_range(1024, 4000));
        cfg_ps = 10'($urandom_range(int'(cfg_p) / 4 + 1, 1023));
      end else begin
        cfg_n  = 10'($urandom_range(1, 12));
        cfg_ns = 10'($urandom_range(1, 6));
        cfg_p  = 12'($urandom_range(1, 12));
        cfg_ps = 10'($urandom_range(1, 6));
      end
      if (t % 4 == 0) cfg_ns = cfg_n;
      run_layer();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
